mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store access controller between the core's MEM-stage request and the word-wide data memory.
//  Data memory: 64 x 32, async-read (dm_read gated), write on posedge clk.
//  Converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW into word accesses:
//   - extracts and sign/zero-extends load data;
//   - performs read-modify-write for sub-word stores;
//   - flags misaligned or illegal accesses.
//  Stalls the core (req_ready=0) while a multi-cycle access is in flight.
// PARAMETERS
//  ADDR_W  6  data-memory word-address width; byte address is ADDR_W+2 bits
// PORTS
//  clk            in   1         system clock, all state on posedge
//  rst_n          in   1         asynchronous, active-low reset
//  req_valid      in   1         MEM stage presents an access
//  req_ready      out  1         controller idle; request accepted when valid&&ready
//  req_write      in   1         1=store, 0=load
//  req_funct3     in   3         RV32I funct3 of the load/store
//  req_addr       in   ADDR_W+2  byte address
//  req_wdata      in   32        store data (rs2), low bytes used for SB/SH
//  resp_valid     out  1         one-cycle pulse: access complete
//  resp_rdata     out  32        extended load data (0 for stores/errors), held until next resp
//  resp_err       out  1         misaligned/illegal, valid with resp_valid
//  dm_read        out  1         data-memory read enable
//  dm_write       out  1         data-memory write enable
//  dm_addr        out  ADDR_W    data-memory word address
//  dm_wdata       out  32        data-memory write data
//  dm_rdata       in   32        data-memory read data (combinational)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0;
//   - dm_read=0, dm_write=0, dm_addr=0, dm_wdata=0; req_ready=1.
//  States:
//   - IDLE: req_ready=1. On accept, latch write/funct3/addr/wdata.
//       illegal or misaligned -> RESP; LW-type load -> RD; SB/SH -> RD; SW -> WR.
//   - RD: dm_read=1, dm_addr=latched addr[ADDR_W+1:2]; capture dm_rdata into word reg.
//       load -> RESP; SB/SH -> WR.
//   - WR: dm_write=1 for exactly this cycle; dm_wdata=merged word.
//       SW: full wdata. SB: byte lane addr[1:0] replaced. SH: half lane addr[1] replaced. -> RESP.
//   - RESP: resp_valid=1 one cycle; req_ready=0 -> IDLE.
//  Latency (accept at edge T): SW resp at T+2; load resp at T+2; SB/SH resp at T+3; error resp at T+1.
//  Legality:
//   - legal loads: funct3 000,001,010,100,101; legal stores: 000,001,010; all others -> resp_err=1.
//   - misaligned: LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0 -> resp_err=1.
//   - error responses: no dm_read/dm_write ever asserted, resp_rdata=0.
//  Load extension: LB/LH sign-extend selected lane; LBU/LHU zero-extend; LW passthrough.
//  Busy rules:
//   - req_valid outside IDLE is ignored; requester must hold the request until accepted.
//   - back-to-back accepts are possible one cycle after RESP.
//  dm_* outputs are decoded from state, so reset mid-op drops dm_write immediately:
//   - abandoned RMW leaves memory unchanged if reset precedes the WR-cycle edge;
//   - no response is emitted for an aborted access.
// STRUCTURE
//  Shared package mem_pkg:
//   - funct3 constants F3_B/H/W/BU/HU;
//   - FSM state encoding S_IDLE/S_RD/S_WR/S_RESP (2-bit).
//  Sub-module mem_lane_align (combinational): load extract/extend and store byte-lane merge;
//   instantiated once, controller holds FSM and latches.
// TESTING
//  Preload word1=32'h8091A2B3.
//  1 LW addr 0x04 -> resp_valid at T+2, resp_rdata=32'h8091A2B3, resp_err=0.
//  2 Lane extension:
//     LB 0x07 -> 32'hFFFFFF80; LBU 0x07 -> 32'h00000080; LH 0x04 -> 32'hFFFFA2B3; LHU 0x06 -> 32'h00008091.
//  3 SB 0x05 wdata 32'h000000EE -> dm_write high only at T+2, resp at T+3; LW 0x04 -> 32'h8091EEB3.
//  4 SH 0x06 wdata 32'h00001234 -> word1=32'h1234EEB3;
//     SW 0x08 wdata 32'hDEADBEEF -> dm_write at T+1, word2=32'hDEADBEEF.
//  5 LW 0x06 / SH 0x05 / funct3=3'b011 -> resp_err=1 at T+1, dm_read=dm_write=0 throughout, resp_rdata=0.
//  6 rst_n low during RD of SB 0x04:
//     dm_write never asserted, no resp_valid, word1 unchanged, req_ready=1 immediately;
//     req_valid held during busy accepted only once.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared load/store decode constants, FSM encoding and legality check.
// Contents:
//   F3_B/H/W/BU/HU  RV32I load/store funct3 codes
//   state_t         controller FSM state (S_IDLE/S_RD/S_WR/S_RESP)
//   access_err()    1 when an access is illegal or misaligned
package mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  function automatic logic access_err(input logic wr, input logic [2:0] f3, input logic [1:0] off);
    logic legal, mis;
    legal = wr ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
               : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    mis = (f3 == F3_W && off != 2'b00) || ((f3 == F3_H || f3 == F3_HU) && off[0]);
    return !legal || mis;
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational load lane extract/extend and store lane merge.
// Ports:
//   funct3  in   access width/signedness
//   off     in   byte offset within the word (addr[1:0])
//   rword   in   word read from memory (load source)
//   mword   in   previously read word (store merge base)
//   wdata   in   store data, low bytes used for SB/SH
//   ldata   out  extended load data
//   sdata   out  merged word to write back
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rword,
  input  logic [31:0] mword,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] sdata
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] bmask, hmask;

  assign b = 8'(rword >> {off, 3'b000});
  assign h = 16'(rword >> {off[1], 4'b0000});
  assign ldata = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'd0, b} :
                 funct3 == F3_HU ? {16'd0, h} : rword;

  // Lane masks select the bytes replaced by the store; the store data is
  // replicated across all lanes so the mask alone picks the right copy.
  assign bmask = 32'h0000_00FF << {off, 3'b000};
  assign hmask = 32'h0000_FFFF << {off[1], 4'b0000};
  assign sdata = funct3 == F3_B ? (mword & ~bmask) | ({4{wdata[7:0]}} & bmask) :
                 funct3 == F3_H ? (mword & ~hmask) | ({2{wdata[15:0]}} & hmask) : wdata;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store controller over a word-wide data memory.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/ready/write/funct3    MEM-stage request handshake and type
//   req_addr, req_wdata             byte address, store data
//   resp_valid/rdata/err            one-cycle completion pulse, load data, error flag
//   dm_read/write/addr/wdata        data-memory control (decoded from state)
//   dm_rdata                        data-memory combinational read data
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              dm_read,
  output logic              dm_write,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);
  state_t            state;
  logic              wr_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wd_q, word_q, ldata, sdata;

  mem_lane_align u_align (
    .funct3(f3_q),
    .off   (addr_q[1:0]),
    .rword (dm_rdata),
    .mword (word_q),
    .wdata (wd_q),
    .ldata (ldata),
    .sdata (sdata)
  );

  // Memory strobes come straight from state so an async reset drops them at once.
  assign req_ready = state == S_IDLE;
  assign dm_read   = state == S_RD;
  assign dm_write  = state == S_WR;
  assign dm_addr   = addr_q[ADDR_W+1:2];
  assign dm_wdata  = state == S_WR ? sdata : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_q       <= 1'b0;
      f3_q       <= 3'd0;
      addr_q     <= '0;
      wd_q       <= 32'd0;
      word_q     <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            wr_q   <= req_write;
            f3_q   <= req_funct3;
            addr_q <= req_addr;
            wd_q   <= req_wdata;
            if (access_err(req_write, req_funct3, req_addr[1:0])) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state <= (req_write && req_funct3 == F3_W) ? S_WR : S_RD;
            end
          end
        end
        S_RD: begin
          word_q <= dm_rdata;
          if (wr_q) begin
            state <= S_WR;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= ldata;
          end
        end
        S_WR: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'd0;
        end
        default: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and randomized checks of mem_access_ctrl against a byte-level reference model.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dm_read, dm_write;
  logic [5:0]  dm_addr;
  logic [31:0] dm_wdata, dm_rdata;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  int checks = 0;
  int errors = 0;
  int accepts = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = dm_read ? mem[dm_addr] : 32'd0;
  always @(posedge clk) if (dm_write) mem[dm_addr] <= dm_wdata;
  always @(posedge clk) if (rst_n && req_valid && req_ready) accepts <= accepts + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: works on bytes and access size, independent of the controller's states.
  task automatic ref_op(input logic wr, input logic [2:0] f3, input logic [7:0] addr, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd, output int lat,
                        output logic [7:0] rm, output logic [7:0] wm);
    int sz, w, sh;
    logic legal;
    logic [31:0] word, v, mask;
    sz = 1 << f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || (int'(addr) % sz != 0);
    rd = 32'd0; lat = 1; rm = 8'd0; wm = 8'd0;
    if (err) return;
    w = int'(addr) / 4;
    sh = 8 * (int'(addr) % 4);
    word = ref_mem[w];
    if (!wr) begin
      v = word >> sh;
      lat = 2; rm = 8'b10;
      case (f3)
        3'd0: rd = v[7] ? {24'd0, v[7:0]} - 32'd256 : {24'd0, v[7:0]};
        3'd1: rd = v[15] ? {16'd0, v[15:0]} - 32'd65536 : {16'd0, v[15:0]};
        3'd4: rd = {24'd0, v[7:0]};
        3'd5: rd = {16'd0, v[15:0]};
        default: rd = word;
      endcase
    end else begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1) << sh;
      ref_mem[w] = (word & ~mask) | ((wd << sh) & mask);
      lat = (sz == 4) ? 2 : 3;
      rm = (sz == 4) ? 8'd0 : 8'b10;
      wm = (sz == 4) ? 8'b10 : 8'b100;
    end
  endtask

  // Called at a negedge with the controller idle; returns at a negedge with it idle again.
  task automatic do_access(input logic wr, input logic [2:0] f3, input logic [7:0] addr,
                           input logic [31:0] wd, input logic hold);
    logic e_err, g_err;
    logic [31:0] e_rd, g_rd;
    logic [7:0] e_rm, e_wm, g_rm, g_wm;
    int e_lat, g_lat, a0;
    ref_op(wr, f3, addr, wd, e_err, e_rd, e_lat, e_rm, e_wm);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    check("ready", 32'(req_ready), 32'd1);
    a0 = accepts;
    g_lat = 0; g_rm = 8'd0; g_wm = 8'd0; g_err = 1'b0; g_rd = 32'hx;
    for (int n = 1; n <= 6 && g_lat == 0; n++) begin
      @(negedge clk);
      if (dm_read) g_rm[n] = 1'b1;
      if (dm_write) g_wm[n] = 1'b1;
      if (resp_valid) begin
        g_lat = n; g_err = resp_err; g_rd = resp_rdata;
      end
      if (resp_valid || (n == 1 && !hold)) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    check("latency", 32'(g_lat), 32'(e_lat));
    check("err", 32'(g_err), 32'(e_err));
    check("rdata", g_rd, e_rd);
    check("rd_cycles", 32'(g_rm), 32'(e_rm));
    check("wr_cycles", 32'(g_wm), 32'(e_wm));
    check("accepts", 32'(accepts - a0), 32'd1);
    @(negedge clk);
    check("pulse", 32'(resp_valid), 32'd0);
    check("rdata_hold", resp_rdata, e_rd);
    last_rd = g_rd;
  endtask

  initial begin
    logic [31:0] saved;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 8'd0; req_wdata = 32'd0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'h8091A2B3;
    ref_mem[1] = 32'h8091A2B3;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_dm_ctl", {30'd0, dm_read, dm_write}, 32'd0);
    check("rst_dm_addr", 32'(dm_addr), 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_access(1'b0, F3_W, 8'h04, 32'd0, 1'b0);          check("spec_lw", last_rd, 32'h8091A2B3);
    do_access(1'b0, F3_B, 8'h07, 32'd0, 1'b0);          check("spec_lb", last_rd, 32'hFFFFFF80);
    do_access(1'b0, F3_BU, 8'h07, 32'd0, 1'b0);         check("spec_lbu", last_rd, 32'h00000080);
    do_access(1'b0, F3_H, 8'h04, 32'd0, 1'b0);          check("spec_lh", last_rd, 32'hFFFFA2B3);
    do_access(1'b0, F3_HU, 8'h06, 32'd0, 1'b0);         check("spec_lhu", last_rd, 32'h00008091);
    do_access(1'b1, F3_B, 8'h05, 32'h000000EE, 1'b0);
    do_access(1'b0, F3_W, 8'h04, 32'd0, 1'b0);          check("spec_sb", last_rd, 32'h8091EEB3);
    do_access(1'b1, F3_H, 8'h06, 32'h00001234, 1'b0);   check("spec_sh_mem", mem[1], 32'h1234EEB3);
    do_access(1'b1, F3_W, 8'h08, 32'hDEADBEEF, 1'b0);   check("spec_sw_mem", mem[2], 32'hDEADBEEF);
    do_access(1'b0, F3_W, 8'h06, 32'd0, 1'b0);
    do_access(1'b1, F3_H, 8'h05, 32'hFFFF_FFFF, 1'b0);
    do_access(1'b0, 3'b011, 8'h04, 32'd0, 1'b0);
    do_access(1'b1, 3'b100, 8'h04, 32'd0, 1'b1);
    do_access(1'b0, F3_W, 8'h08, 32'd0, 1'b1);
    do_access(1'b1, F3_B, 8'h0B, 32'h0000_0011, 1'b1);

    // Reset while the sub-word store is in its read cycle.
    saved = mem[1];
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B; req_addr = 8'h04; req_wdata = 32'h0000_0055;
    @(negedge clk);
    check("abort_in_rd", 32'(dm_read), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_dm_ctl", {30'd0, dm_read, dm_write}, 32'd0);
    @(negedge clk);
    check("abort_no_resp", 32'(resp_valid), 32'd0);
    check("abort_dm_write", 32'(dm_write), 32'd0);
    check("abort_mem", mem[1], saved);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_after", 32'(resp_valid), 32'd0);

    for (int i = 0; i < 250; i++) begin
      logic wr, hd;
      logic [2:0] f3;
      logic [7:0] ad;
      wr = 1'($urandom_range(0, 1));
      hd = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      ad = 8'($urandom_range(0, 255));
      do_access(wr, f3, ad, $urandom, hd);
    end

    for (int i = 0; i < 64; i++) check("mem_final", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
